// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of a simple dual-port BRAM (port A write, port B read).
// Round-robin between requesters, with an optional ownership lock.
// The lock feature is compiled in only when BRAM_PORT_ARBITER_LOCK_EN is defined.
// Without it the lock inputs are ignored and arbitration is plain round-robin.

// Per-requester read return: one-cycle delayed valid that lines up with BRAM read latency
module bram_arb_rd_lane #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_gnt,
  input  logic [DW-1:0] doutb,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);
  logic pend;

  // remember a granted read for the cycle the BRAM data appears
  always_ff @(posedge clk) begin
    if (rst) pend <= 1'b0;
    else     pend <= rd_gnt;
  end

  // masking with rst keeps a read granted just before reset from surfacing
  assign rvalid = pend & ~rst;
  assign rdata  = rvalid ? doutb : '0;
endmodule

module bram_port_arbiter #(
  parameter int AW       = 14,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            req0,
  input  logic [AW-1:0]   addr0,
  input  logic [DW-1:0]   wdata0,
  input  logic [DW/8-1:0] we0,
  input  logic            lock0,
  output logic            gnt0,
  output logic            rvalid0,
  output logic [DW-1:0]   rdata0,
  input  logic            req1,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   wdata1,
  input  logic [DW/8-1:0] we1,
  input  logic            lock1,
  output logic            gnt1,
  output logic            rvalid1,
  output logic [DW-1:0]   rdata1,
  output logic [AW-1:0]   bram_addra,
  output logic [DW-1:0]   bram_dina,
  output logic [DW/8-1:0] bram_wea,
  output logic [AW-1:0]   bram_addrb,
  input  logic [DW-1:0]   bram_doutb
);
  localparam int BW = DW/8;

  logic [1:0]         req, gnt, rd_gnt, rvalid;
  logic [1:0][AW-1:0] addr_v;
  logic [1:0][DW-1:0] wdata_v, rdata_v;
  logic [1:0][BW-1:0] we_v;
  logic               last_win;

  assign req     = {req1, req0};
  assign addr_v  = {addr1, addr0};
  assign wdata_v = {wdata1, wdata0};
  assign we_v    = {we1, we0};

`ifdef BRAM_PORT_ARBITER_LOCK_EN
  typedef enum logic {OPEN, LOCKED} lock_state_t;
  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

  lock_state_t state, state_nxt;
  logic        owner, owner_nxt;
  logic [7:0]  cnt, cnt_nxt, cnt_inc;
  logic [1:0]  lock;

  assign lock    = {lock1, lock0};
  assign cnt_inc = (cnt == MAX_CNT) ? cnt : cnt + 8'd1;

  // lock state register
  always_ff @(posedge clk) begin
    if (RST) begin
      state <= OPEN;
      owner <= 1'b0;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // lock transitions; reaching MAX_LOCK drops to OPEN, and since last_win then
  // names the owner, round-robin hands the next cycle to the other side
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    case (state)
      OPEN: begin
        if (|gnt && lock[gnt[1]]) begin
          state_nxt = LOCKED;
          owner_nxt = gnt[1];
          cnt_nxt   = 8'd1;
        end
      end
      LOCKED: begin
        if (!req[owner] || !lock[owner]) begin
          state_nxt = OPEN;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == MAX_CNT) state_nxt = OPEN;
        end
      end
      default: state_nxt = OPEN;
    endcase
  end

  // arbitration: a held lock shuts out the non-owner entirely
  always_comb begin
    gnt = '0;
    if (!RST) begin
      if (state == LOCKED) gnt[owner] = req[owner];
      else if (&req)       gnt[~last_win] = 1'b1;
      else                 gnt = req;
    end
  end
`else
  logic unused_lock;
  localparam int unused_max_lock = MAX_LOCK;
  assign unused_lock = lock0 | lock1;

  // arbitration: pure round-robin on contention
  always_comb begin
    gnt = '0;
    if (!RST) begin
      if (&req) gnt[~last_win] = 1'b1;
      else      gnt = req;
    end
  end
`endif

  // last winner; reset value 1 lets requester 0 win the first contention
  always_ff @(posedge clk) begin
    if (RST)       last_win <= 1'b1;
    else if (|gnt) last_win <= gnt[1];
  end

  // BRAM port mux: winner drives both ports, idle cycles drive zeros
  always_comb begin
    bram_addra = '0;
    bram_addrb = '0;
    bram_dina  = '0;
    bram_wea   = '0;
    if (|gnt) begin
      bram_addra = addr_v[gnt[1]];
      bram_addrb = addr_v[gnt[1]];
      bram_dina  = wdata_v[gnt[1]];
      bram_wea   = we_v[gnt[1]];
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_lane
    assign rd_gnt[i] = gnt[i] & ~|we_v[i];
    bram_arb_rd_lane #(.DW(DW)) u_rd (
      .clk   (clk),
      .rst   (RST),
      .rd_gnt(rd_gnt[i]),
      .doutb (bram_doutb),
      .rvalid(rvalid[i]),
      .rdata (rdata_v[i])
    );
  end

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign rvalid0 = rvalid[0];
  assign rvalid1 = rvalid[1];
  assign rdata0  = rdata_v[0];
  assign rdata1  = rdata_v[1];
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: BRAM behavioural model, directed scenarios and
// randomized traffic checked every cycle against a rule-level reference model.
module tb_bram_port_arbiter;
  localparam int AW = 14, DW = 32, BW = 4, ML = 4;
`ifdef BRAM_PORT_ARBITER_LOCK_EN
  localparam bit LOCK_MODEL = 1'b1;
`else
  localparam bit LOCK_MODEL = 1'b0;
`endif

  logic          clk = 1'b0, RST = 1'b1;
  logic          req0 = 0, req1 = 0, lock0 = 0, lock1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [BW-1:0] we0 = '0, we1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] bram_addra, bram_addrb;
  logic [DW-1:0] bram_dina, bram_doutb;
  logic [BW-1:0] bram_wea;

  bram_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .RST(RST),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .lock0(lock0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .lock1(lock1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
    .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
  );

  always #5 clk = ~clk;

  // BRAM: byte-enabled write on port A, registered read on port B
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    for (int b = 0; b < BW; b++)
      if (bram_wea[b]) ram[bram_addra][b*8 +: 8] <= bram_dina[b*8 +: 8];
    bram_doutb <= ram[bram_addrb];
  end

  int vecs = 0, errs = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model state
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            m_last = 1, m_locked = 0, m_owner = 0, m_cnt = 0, win;
  logic [1:0]    m_pend = '0, rq, lk;
  logic [DW-1:0] m_pdata [2];
  logic [AW-1:0] ad [2];
  logic [DW-1:0] wd [2];
  logic [BW-1:0] wev [2];

  // per-cycle compare, then advance the model to the next edge
  always @(negedge clk) begin
    rq = {req1, req0}; lk = {lock1, lock0};
    ad[0] = addr0; ad[1] = addr1; wd[0] = wdata0; wd[1] = wdata1; wev[0] = we0; wev[1] = we1;
    win = -1;
    if (!RST) begin
      if (LOCK_MODEL && m_locked != 0) begin
        if (rq[m_owner]) win = m_owner;
      end else if (rq == 2'b11) win = 1 - m_last;
      else if (rq[0]) win = 0;
      else if (rq[1]) win = 1;
    end
    chk("gnt0", gnt0, win == 0);
    chk("gnt1", gnt1, win == 1);
    chk("rvalid0", rvalid0, m_pend[0] && !RST);
    chk("rvalid1", rvalid1, m_pend[1] && !RST);
    chk("rdata0", rdata0, (m_pend[0] && !RST) ? m_pdata[0] : '0);
    chk("rdata1", rdata1, (m_pend[1] && !RST) ? m_pdata[1] : '0);
    chk("addra", 32'(bram_addra), win >= 0 ? 32'(ad[win]) : 0);
    chk("addrb", 32'(bram_addrb), win >= 0 ? 32'(ad[win]) : 0);
    chk("dina", bram_dina, win >= 0 ? wd[win] : '0);
    chk("wea", 32'(bram_wea), win >= 0 ? 32'(wev[win]) : 0);

    if (RST) begin
      m_last = 1; m_locked = 0; m_cnt = 0; m_pend = '0;
    end else begin
      m_pend = '0;
      if (win >= 0) begin
        if (wev[win] == '0) begin
          m_pend[win] = 1'b1;
          m_pdata[win] = mem[ad[win]];
        end else begin
          for (int b = 0; b < BW; b++)
            if (wev[win][b]) mem[ad[win]][b*8 +: 8] = wd[win][b*8 +: 8];
        end
      end
      if (LOCK_MODEL) begin
        if (m_locked != 0) begin
          if (!rq[m_owner] || !lk[m_owner]) m_locked = 0;
          else begin
            if (m_cnt < ML) m_cnt++;
            if (m_cnt == ML) m_locked = 0;
          end
        end else if (win >= 0 && lk[win]) begin
          m_locked = 1; m_owner = win; m_cnt = 1;
        end
      end
      if (win >= 0) m_last = win;
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin ram[i] = '0; mem[i] = '0; end
    // requests present during reset must be suppressed
    req0 = 1; req1 = 1; we0 = 4'hF;
    mid();
    chk("rst_gnt0", gnt0, 1'b0);
    chk("rst_wea", 32'(bram_wea), 0);
    chk("rst_rvalid0", rvalid0, 1'b0);
    step(); step();

    // both read: 0 first, then alternate, rvalid one cycle later
    RST = 0; we0 = 0; addr0 = 14'd5; addr1 = 14'd6;
    mid(); chk("alt_c1_gnt0", gnt0, 1'b1); chk("alt_c1_gnt1", gnt1, 1'b0);
    step(); mid(); chk("alt_c2_gnt1", gnt1, 1'b1); chk("alt_c2_rv0", rvalid0, 1'b1);
    step(); mid(); chk("alt_c3_gnt0", gnt0, 1'b1); chk("alt_c3_rv1", rvalid1, 1'b1);

    // full write then read back on requester 0
    step(); req1 = 0; addr0 = 14'h0010; wdata0 = 32'hDEADBEEF; we0 = 4'hF;
    mid(); chk("wr0_gnt0", gnt0, 1'b1); chk("wr0_wea", 32'(bram_wea), 32'hF);
    step(); we0 = 0;
    mid(); chk("rd0_gnt0", gnt0, 1'b1);
    step(); req0 = 0;
    mid(); chk("rd0_rvalid0", rvalid0, 1'b1); chk("rd0_rdata0", rdata0, 32'hDEADBEEF);
    chk("rd0_rvalid1", rvalid1, 1'b0);

    // partial write on requester 1
    step(); req1 = 1; addr1 = 14'h0020; wdata1 = 32'h11223344; we1 = 4'hF;
    step(); wdata1 = 32'h0000AB00; we1 = 4'b0010;
    step(); we1 = 0; wdata1 = 0;
    step(); req1 = 0;
    mid(); chk("pw_rvalid1", rvalid1, 1'b1); chk("pw_rdata1", rdata1, 32'h1122AB44);
    chk("pw_rvalid0", rvalid0, 1'b0);

    // reset right after a granted read drops the read return
    step(); req0 = 1; addr0 = 14'h0010;
    step(); RST = 1; req0 = 0;
    mid(); chk("rr_rv0_inrst", rvalid0, 1'b0);
    step(); RST = 0; req0 = 1; req1 = 1;
    mid(); chk("rr_rv0_after", rvalid0, 1'b0); chk("rr_gnt0", gnt0, 1'b1); chk("rr_gnt1", gnt1, 1'b0);

    // lock0 held with contention
    step(); RST = 1; req0 = 0; req1 = 0;
    step(); RST = 0; req0 = 1; req1 = 1; lock0 = 1; lock1 = 0;
    for (int i = 0; i < 10; i++) begin
      logic e0;
      e0 = LOCK_MODEL ? ((i % 5) < 4) : ((i % 2) == 0);
      mid(); chk("lock_seq_gnt0", gnt0, e0); chk("lock_seq_gnt1", gnt1, !e0);
      step();
    end
    req0 = 0; req1 = 0; lock0 = 0;

    // randomized traffic
    repeat (3000) begin
      step();
      RST    = ($urandom_range(0, 99) == 0);
      req0   = ($urandom_range(0, 3) != 0);
      req1   = ($urandom_range(0, 3) != 0);
      lock0  = ($urandom_range(0, 2) != 0);
      lock1  = ($urandom_range(0, 2) != 0);
      addr0  = AW'($urandom_range(0, 15));
      addr1  = AW'($urandom_range(0, 15));
      wdata0 = $urandom;
      wdata1 = $urandom;
      we0    = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      we1    = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
    end
    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
